// File: rtl/matrix_mult_pkg.sv
// Shared definitions for the sequential NxN matrix multiplier: FSM state
// encoding and the result-width helper used to size accumulators and outputs.
package matrix_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest dot product of n DW-bit terms, for signed or unsigned operands.
    function automatic int calc_cw(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: extends both operands to CW bits
// (sign or zero per mode), multiplies, and adds to the running sum.
module mac_unit #(
    parameter int DW = 8,
    parameter int CW = 18
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [CW-1:0] acc_in,
    input  logic          signed_mode,
    output logic [CW-1:0] acc_out
);

    logic [CW-1:0] a_ext;
    logic [CW-1:0] b_ext;
    logic [CW-1:0] prod;

    assign a_ext = signed_mode ? {{(CW-DW){a[DW-1]}}, a} : {{(CW-DW){1'b0}}, a};
    assign b_ext = signed_mode ? {{(CW-DW){b[DW-1]}}, b} : {{(CW-DW){1'b0}}, b};

    // A CW-bit product of extended operands is exact modulo 2^CW in both modes.
    assign prod    = a_ext * b_ext;
    assign acc_out = acc_in + prod;

endmodule

// File: rtl/matrix_mult_param.sv
// Sequential NxN matrix multiplier: one MAC per cycle, k innermost, results
// collected in a buffer and published to c_flat all at once on completion.
module matrix_mult_param
    import matrix_mult_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int DW = 8,
    localparam int CW = calc_cw(N, DW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*N*DW-1:0] b_flat,
    output logic [N*N*CW-1:0] c_flat,
    output logic              busy,
    output logic              done
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t              state_reg;
    logic [IW-1:0]       i_reg;
    logic [IW-1:0]       j_reg;
    logic [IW-1:0]       k_reg;
    logic [CW-1:0]       acc_reg;
    logic [N*N*DW-1:0]   a_reg;
    logic [N*N*DW-1:0]   b_reg;
    logic                sm_reg;
    logic [N*N*CW-1:0]   buf_reg;

    logic [DW-1:0]       a_elem;
    logic [DW-1:0]       b_elem;
    logic [CW-1:0]       acc_next;

    assign a_elem = a_reg[(int'(i_reg) * N + int'(k_reg)) * DW +: DW];
    assign b_elem = b_reg[(int'(k_reg) * N + int'(j_reg)) * DW +: DW];

    mac_unit #(
        .DW(DW),
        .CW(CW)
    ) u_mac (
        .a          (a_elem),
        .b          (b_elem),
        .acc_in     (acc_reg),
        .signed_mode(sm_reg),
        .acc_out    (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            acc_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sm_reg    <= 1'b0;
            buf_reg   <= '0;
            c_flat    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a_flat;
                        b_reg     <= b_flat;
                        sm_reg    <= signed_mode;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        k_reg     <= '0;
                        acc_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (k_reg == LAST) begin
                        buf_reg[(int'(i_reg) * N + int'(j_reg)) * CW +: CW] <= acc_next;
                        acc_reg <= '0;
                        k_reg   <= '0;
                        if (j_reg == LAST) begin
                            j_reg <= '0;
                            if (i_reg == LAST) begin
                                i_reg     <= '0;
                                // Final element is the top slot; splice it in so
                                // c_flat is complete on the same edge.
                                c_flat    <= {acc_next, buf_reg[(N*N-1)*CW-1:0]};
                                done      <= 1'b1;
                                state_reg <= DONE;
                            end else begin
                                i_reg <= i_reg + 1'b1;
                            end
                        end else begin
                            j_reg <= j_reg + 1'b1;
                        end
                    end else begin
                        acc_reg <= acc_next;
                        k_reg   <= k_reg + 1'b1;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_param.sv
// Directed bench: a 3x3/8-bit instance driven from a vector table plus
// hand sequences, and a 4x4/4-bit instance for back-to-back operation.
module tb_matrix_mult_param;

    typedef int arr9_t [9];

    typedef struct {
        logic [71:0]  a;
        logic [71:0]  b;
        logic         sm;
        logic [161:0] c;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         start3 = 1'b0;
    logic         sm3 = 1'b0;
    logic [71:0]  a3 = '0;
    logic [71:0]  b3 = '0;
    logic [161:0] c3;
    logic         busy3;
    logic         done3;

    logic         start4 = 1'b0;
    logic         sm4 = 1'b0;
    logic [63:0]  a4 = '0;
    logic [63:0]  b4 = '0;
    logic [159:0] c4;
    logic         busy4;
    logic         done4;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs [4];

    always #5 clk = ~clk;

    matrix_mult_param #(.N(3), .DW(8)) u3 (
        .clk(clk), .rst(rst), .start(start3), .signed_mode(sm3),
        .a_flat(a3), .b_flat(b3), .c_flat(c3), .busy(busy3), .done(done3)
    );

    matrix_mult_param #(.N(4), .DW(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .a_flat(a4), .b_flat(b4), .c_flat(c4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pk8(input arr9_t e);
        logic [71:0] r;
        logic [31:0] t;
        r = '0;
        for (int x = 0; x < 9; x++) begin
            t = e[x];
            r[x*8 +: 8] = t[7:0];
        end
        return r;
    endfunction

    function automatic logic [161:0] pk18(input arr9_t e);
        logic [161:0] r;
        logic [31:0]  t;
        r = '0;
        for (int x = 0; x < 9; x++) begin
            t = e[x];
            r[x*18 +: 18] = t[17:0];
        end
        return r;
    endfunction

    task automatic set_vec(input int idx, input arr9_t ea, input arr9_t eb,
                           input logic sm, input arr9_t ec);
        vecs[idx].a  = pk8(ea);
        vecs[idx].b  = pk8(eb);
        vecs[idx].sm = sm;
        vecs[idx].c  = pk18(ec);
    endtask

    // Launch on the 3x3 instance and count cycles from the start edge to done.
    task automatic run3(input int idx, output int lat);
        @(negedge clk);
        a3 = vecs[idx].a;
        b3 = vecs[idx].b;
        sm3 = vecs[idx].sm;
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        lat = 0;
        while (lat < 100 && !done3) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    initial begin
        arr9_t ea, eb, ec;
        int lat, npulse;
        logic [159:0] exp4a, exp4b;
        logic [63:0]  ident4;

        ea = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        eb = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        ec = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        set_vec(0, ea, eb, 1'b0, ec);
        ea = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        ec = '{195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075};
        set_vec(1, ea, ea, 1'b0, ec);
        ec = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
        set_vec(2, ea, ea, 1'b1, ec);
        ea = '{2, 0, 0, 0, 2, 0, 0, 0, 2};
        eb = '{-1, -2, -3, 4, 5, 6, -7, 8, -9};
        ec = '{-2, -4, -6, 8, 10, 12, -14, 16, -18};
        set_vec(3, ea, eb, 1'b1, ec);

        // Reset state of both instances
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy3", 256'(busy3), 256'(0));
        chk("rst_done3", 256'(done3), 256'(0));
        chk("rst_c3", 256'(c3), 256'(0));
        chk("rst_busy4", 256'(busy4), 256'(0));
        chk("rst_c4", 256'(c4), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run3(v, lat);
            chk("latency", 256'(lat), 256'(27));
            chk("c_flat", 256'(c3), 256'(vecs[v].c));
            chk("busy_in_done", 256'(busy3), 256'(1));
            @(posedge clk);
            #1;
            chk("done_fall", 256'(done3), 256'(0));
            chk("busy_fall", 256'(busy3), 256'(0));
            $display("txn vec%0d sm=%0d latency=%0d c_flat=%h", v, vecs[v].sm, lat, c3);
        end

        // Second start mid-RUN with different operands must be ignored
        @(negedge clk);
        a3 = vecs[0].a;
        b3 = vecs[0].b;
        sm3 = 1'b0;
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        lat = 0;
        while (lat < 100 && !done3) begin
            @(posedge clk);
            #1 lat++;
            if (lat == 10) begin
                a3 = vecs[1].a;
                b3 = vecs[1].b;
                sm3 = 1'b1;
                start3 = 1'b1;
            end else if (lat == 11) begin
                start3 = 1'b0;
            end
        end
        chk("ignore_start_lat", 256'(lat), 256'(27));
        chk("ignore_start_c", 256'(c3), 256'(vecs[0].c));
        npulse = 0;
        for (int x = 0; x < 40; x++) begin
            @(posedge clk);
            #1 if (done3) npulse++;
        end
        chk("single_done", 256'(npulse), 256'(0));
        $display("txn ignore_start latency=%0d c_flat=%h", lat, c3);

        // Reset mid-RUN aborts with no done pulse
        @(negedge clk);
        a3 = vecs[1].a;
        b3 = vecs[1].b;
        sm3 = 1'b0;
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 256'(busy3), 256'(0));
        chk("abort_c", 256'(c3), 256'(0));
        chk("abort_done", 256'(done3), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        npulse = 0;
        for (int x = 0; x < 40; x++) begin
            @(posedge clk);
            #1 if (done3) npulse++;
        end
        chk("abort_no_done", 256'(npulse), 256'(0));
        run3(3, lat);
        chk("post_rst_lat", 256'(lat), 256'(27));
        chk("post_rst_c", 256'(c3), 256'(vecs[3].c));
        $display("txn post_reset latency=%0d c_flat=%h", lat, c3);

        // 4x4 / 4-bit: identity times B gives B; start held for back-to-back jobs
        ident4 = '0;
        exp4a = '0;
        exp4b = '0;
        for (int x = 0; x < 16; x++) begin
            b4[x*4 +: 4] = 4'(x);
            exp4a[x*10 +: 10] = 10'(x);
            exp4b[x*10 +: 10] = 10'(15 - x);
        end
        for (int r = 0; r < 4; r++) ident4[(r*4 + r)*4 +: 4] = 4'd1;
        @(negedge clk);
        a4 = ident4;
        start4 = 1'b1;
        @(posedge clk);
        #1 lat = 0;
        while (lat < 200 && !done4) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("n4_latency", 256'(lat), 256'(64));
        chk("n4_c", 256'(c4), 256'(exp4a));
        $display("txn n4_job1 latency=%0d c_flat=%h", lat, c4);
        for (int x = 0; x < 16; x++) b4[x*4 +: 4] = 4'(15 - x);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (lat < 200 && !done4);
        chk("n4_period", 256'(lat), 256'(66));
        chk("n4_c2", 256'(c4), 256'(exp4b));
        $display("txn n4_job2 period=%0d c_flat=%h", lat, c4);
        start4 = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_mult_param.md
MATRIX_MULT_PARAM -- requirements
Module: matrix_mult_param

Interface
REQ-001 Parameter N: default 3; matrix dimension, square NxN, N >= 2.
REQ-002 Parameter DW: default 8; operand element width in bits.
REQ-003 Localparam CW: 2*DW + clog2(N); result element width, overflow-free for both signed and unsigned operands.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 signed_mode  input  1  1 = operands two's complement, 0 = unsigned; sampled with start.
REQ-008 a_flat  input  N*N*DW  matrix A; element (r,c) at bits [(r*N+c)*DW +: DW].
REQ-009 b_flat  input  N*N*DW  matrix B; same packing as A.
REQ-010 c_flat  output  N*N*CW  result C = A x B; element (r,c) at bits [(r*N+c)*CW +: CW].
REQ-011 busy  output  1  high in RUN and DONE states.
REQ-012 done  output  1  single-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, held in a registered state variable.
REQ-014 In IDLE with start=1 at edge T, the block SHALL latch a_flat, b_flat and signed_mode, clear the index counters i, j, k and the accumulator, and enter RUN.
REQ-015 Each RUN cycle SHALL perform exactly one MAC: acc += A[i][k]*B[k][j].
REQ-016 Operand extension SHALL be sign-extension when the latched signed_mode is 1 and zero-extension otherwise; the product SHALL be extended to CW.
REQ-017 Index order SHALL be k innermost, then j, then i.
REQ-018 When k=N-1, the final sum SHALL be written into internal buffer element (i,j) and acc SHALL clear.
REQ-019 After the MAC with i=j=k=N-1, completing at edge T+N^3, the block SHALL enter DONE and copy the whole buffer into c_flat in the same edge.
REQ-020 done SHALL be 1 only during the DONE state, exactly one cycle, i.e. the cycle following edge T+N^3; the next edge SHALL return to IDLE.
REQ-021 Total latency from start accepted to done asserted SHALL be N^3 cycles, which is 27 for N=3.
REQ-022 c_flat SHALL remain stable from its DONE update until the next DONE update and SHALL never expose partial results.
REQ-023 start SHALL be ignored while busy=1, including in the DONE cycle; operand or mode changes during RUN SHALL have no effect.
REQ-024 start held continuously high SHALL launch a new computation on the first IDLE cycle after DONE, giving one job per N^3+2 cycles.
REQ-025 busy SHALL be 0 only in IDLE.

Reset
REQ-026 Asserting rst at any time, including mid-RUN, SHALL immediately force state IDLE.
REQ-027 Reset SHALL set done=0, busy=0, c_flat=0, acc=0, i=j=k=0, the buffer to 0, and latched signed_mode to 0.
REQ-028 An aborted computation SHALL produce no done pulse.
REQ-029 After rst deasserts, the first start sampled in IDLE SHALL begin a fresh computation.

Structure
REQ-030 Shared package matrix_mult_pkg SHALL hold the state enumeration typedef (IDLE/RUN/DONE) and a CW-width helper function.
REQ-031 A single sub-module mac_unit (parameter DW, CW; inputs a, b, acc_in, signed_mode; output acc_out; purely combinational) SHALL implement the extension, multiply and add.
REQ-032 The top level SHALL contain only the FSM, counters, operand latches and buffer.

Verification
REQ-033 N=3, DW=8, unsigned, A=[1 2 3;4 5 6;7 8 9], B=[9 8 7;6 5 4;3 2 1] -> C=[30 24 18;84 69 54;138 114 90]; done exactly 27 cycles after the start edge, for one cycle.
REQ-034 N=3, unsigned, all elements 255 -> every C element = 195075, which requires 18 bits with no truncation.
REQ-035 N=3, signed_mode=1, all elements 8'hFF -> every C element = 3; same data with signed_mode=0 -> 195075.
REQ-036 start pulsed again at cycle 10 of RUN with different A/B -> ignored; result matches the first operands; one done pulse only.
REQ-037 rst asserted at cycle 15 of RUN -> busy=0, c_flat=0, no done; a subsequent start yields the correct result after 27 cycles.
REQ-038 N=4, DW=4, A=identity, B=values 0..15 -> C=B; done 64 cycles after start; start held high gives back-to-back jobs every 66 cycles.
